// File: rtl/slave_shared_pkg.sv
// Shared definitions for the SPI slave and the memory stage behind it:
// frame geometry, command encoding and address/word types.
package slave_shared_pkg;

  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_SIZE;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } cmd_e;

  typedef logic [ADDR_SIZE-1:0] addr_t;
  typedef logic [ADDR_SIZE-1:0] word_t;

endpackage

// File: rtl/spi_ram.sv
// Single-port memory stage behind the SPI slave: executes one address-latch,
// write or read command per valid frame and returns read data to the slave.
module spi_ram
  import slave_shared_pkg::*;
#(
  parameter int MEM_DEPTH = slave_shared_pkg::MEM_DEPTH,
  parameter bit AUTO_INC  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output word_t                dout,
  output logic                 tx_valid,
  output logic                 cmd_err
);

  // Address wrap relies on the natural overflow of addr_t.
  if (MEM_DEPTH != 2 ** ADDR_SIZE) begin : g_depth_check
    $error("spi_ram: MEM_DEPTH must equal 2**ADDR_SIZE");
  end

  cmd_e  cmd;
  addr_t payload;
  addr_t wr_addr;
  addr_t rd_addr;
  logic  rd_armed;
  word_t mem [MEM_DEPTH];

  assign cmd     = cmd_e'(din[ADDR_SIZE+1:ADDR_SIZE]);
  assign payload = din[ADDR_SIZE-1:0];

  // NOTE: the array has no reset so it can map onto block RAM; contents
  // survive rst_n and only WR_DATA ever changes them.
  always_ff @(posedge clk) begin
    if (rx_valid && cmd == WR_DATA) begin
      mem[wr_addr] <= payload;
    end
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // sees pre-edge values, e.g. the read below uses rd_addr as it stood.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr  <= '0;
      rd_addr  <= '0;
      rd_armed <= 1'b0;
      dout     <= '0;
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
    end else begin
      tx_valid <= 1'b0;
      cmd_err  <= 1'b0;
      if (rx_valid) begin
        case (cmd)
          WR_ADDR: wr_addr <= payload;
          WR_DATA: if (AUTO_INC) wr_addr <= wr_addr + 1'b1;
          RD_ADDR: begin
            rd_addr  <= payload;
            rd_armed <= 1'b1;
          end
          RD_DATA: begin
            // Unarmed reads still return mem[0] (rd_addr resets to 0).
            dout     <= mem[rd_addr];
            tx_valid <= 1'b1;
            cmd_err  <= ~rd_armed;
          end
          default: ;
        endcase
      end
    end
  end

  a_cmd_known : assert property (@(posedge clk) disable iff (!rst_n)
    rx_valid |-> !$isunknown(din[ADDR_SIZE+1:ADDR_SIZE]));

endmodule

// File: doc/spi_ram.md
Name: spi_ram

Overview:
- Single-port memory stage directly downstream of the SPI slave.
- Consumes each received frame (rx_data, rx_valid), decodes the 2-bit command field and executes address-latch, write or read operations.
- Returns read data to the slave on tx_data/tx_valid so the slave can shift it out on MISO.
- The top-level SPI wrapper instantiates the slave and this block back-to-back, sharing clk and rst_n.

Parameters:
- MEM_DEPTH, 256, number of memory words; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 8, word and address width; taken from slave_shared_pkg, not overridden locally.
- AUTO_INC, 0, when 1, the write address post-increments after every write-data command.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- din  input  ADDR_SIZE+2  frame from slave; din[ADDR_SIZE+1:ADDR_SIZE] is the command, din[ADDR_SIZE-1:0] is the payload.
- rx_valid  input  1  din qualifier; exactly one command executes per cycle it is high.
- dout  output  ADDR_SIZE  read data to slave (slave tx_data).
- tx_valid  output  1  one-cycle pulse marking dout valid.
- cmd_err  output  1  one-cycle pulse: read-data command issued with no read address latched since reset.

Behaviour:
- Reset (rst_n low, asynchronous, immediate):
  - wr_addr=0, rd_addr=0, rd_armed=0, dout=0, tx_valid=0, cmd_err=0.
  - Memory contents are NOT cleared, so the array maps to block RAM.
- Reset mid-operation: any command in flight is discarded; the first command after deassertion is decoded normally.
- rx_valid=0: no state change except that tx_valid and cmd_err return to 0; dout holds its last value.
- rx_valid=1 at a rising edge, decode din[ADDR_SIZE+1:ADDR_SIZE]:
  - 2'b00 WR_ADDR: wr_addr <= payload.
  - 2'b01 WR_DATA: mem[wr_addr] <= payload. If AUTO_INC=1, wr_addr <= wr_addr+1, wrapping MEM_DEPTH-1 -> 0.
  - 2'b10 RD_ADDR: rd_addr <= payload; rd_armed <= 1.
  - 2'b11 RD_DATA: payload ignored (dummy byte); dout <= mem[rd_addr]; tx_valid <= 1 for exactly one cycle.
    - If rd_armed=0, the data is still returned from rd_addr=0 and cmd_err pulses in the same cycle as tx_valid.
- Latency: dout/tx_valid are registered, visible one cycle after the RD_DATA edge.
- Read-after-write: a RD_DATA arriving the cycle after a WR_DATA to the same address returns the newly written value (write-first ordering is not needed, because only one command executes per cycle).
- tx_valid and cmd_err are pulses. Back-to-back RD_DATA cycles produce back-to-back pulses, each carrying that cycle's read.
- rd_addr and wr_addr are independent registers. Neither command type modifies the other's address.
- Unknown/X command bits: no sequential effect; assertion flags it in simulation.

Decomposition:
- slave_shared_pkg holds ADDR_SIZE and MEM_DEPTH, plus typedef enum logic [1:0] cmd_e {WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11}.
- The package also holds typedefs addr_t and word_t.
- No sub-module needed. The memory array, command decode and output registers live in spi_ram.
- Instantiation belongs in the existing top wrapper alongside the slave.

Test Plan:
- Reset check: rst_n low mid-cycle with tx_valid high -> tx_valid, dout and cmd_err drop to 0 immediately, before the next clk edge.
- Write then read: WR_ADDR 0x3C, WR_DATA 0xA5, RD_ADDR 0x3C, RD_DATA 0x00 -> one cycle after the RD_DATA edge dout=0xA5, tx_valid=1 for one cycle, cmd_err=0.
- Independent addresses: WR_ADDR 0x10, RD_ADDR 0x20 with mem[0x20]=0x77 pre-written, WR_DATA 0x55, RD_DATA -> dout=0x77 and mem[0x10]=0x55.
- Auto-increment wrap: AUTO_INC=1, WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22 -> mem[0xFF]=0x11, mem[0x00]=0x22, wr_addr=0x01.
- Unarmed read: after reset with mem[0x00]=0x9E, RD_DATA -> dout=0x9E, tx_valid=1 and cmd_err=1 in the same cycle.
- Idle hold: rx_valid=0 with din toggling randomly for 20 cycles -> no memory or address change, tx_valid=0, dout stable.
